// File: rtl/jk_sched_pkg.sv
// Shared op encodings and FSM state type for the JK bank scheduler.
package jk_sched_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESTORE = 2'd2,
    RESP    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/jk_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr, wrapping.
module jk_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  int idx;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && req[idx[ID_W-1:0]]) begin
        any                   = 1'b1;
        grant_idx             = idx[ID_W-1:0];
        grant[idx[ID_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler that applies masked hold/clr/set/tog commands to a
// shared JK flip-flop bank and returns the resulting Q to the requester.
module jk_bank_sched
  import jk_sched_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int N_REQ  = 2,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [N_BITS*N_REQ-1:0] req_mask,
  input  logic [N_REQ-1:0]        req_pulse,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_BITS-1:0]       j,
  output logic [N_BITS-1:0]       k,
  input  logic [N_BITS-1:0]       q_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [N_BITS-1:0]       rsp_q
);

  sched_state_e      state, state_nx;
  logic [ID_W-1:0]   ptr, id_r, gidx;
  logic [N_REQ-1:0]  grant;
  logic              any;
  logic [1:0]        op_r, sel_op;
  logic [N_BITS-1:0] mask_r, sel_mask, old_q;
  logic              pulse_r, sel_pulse;

  jk_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any)
  );

  // Select the granted requester's command fields.
  always_comb begin
    sel_op    = OP_HOLD;
    sel_mask  = '0;
    sel_pulse = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op    = req_op[2*i +: 2];
        sel_mask  = req_mask[N_BITS*i +: N_BITS];
        sel_pulse = req_pulse[i];
      end
    end
  end

  // Next-state and J/K decode; everything but req_ready comes from registers.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    j         = '0;
    k         = '0;
    unique case (state)
      IDLE: begin
        // Gated by rst so the strobe is low while the block is held in reset.
        req_ready = rst ? '0 : grant;
        if (any) state_nx = ISSUE;
      end
      ISSUE: begin
        j        = mask_r & {N_BITS{(op_r == OP_SET) || (op_r == OP_TOG)}};
        k        = mask_r & {N_BITS{(op_r == OP_CLR) || (op_r == OP_TOG)}};
        state_nx = pulse_r ? RESTORE : RESP;
      end
      RESTORE: begin
        j        = mask_r & old_q;
        k        = mask_r & ~old_q;
        state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_r;

  // State, command latch, round-robin pointer and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      id_r    <= '0;
      op_r    <= OP_HOLD;
      mask_r  <= '0;
      pulse_r <= 1'b0;
      old_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        id_r    <= gidx;
        op_r    <= sel_op;
        mask_r  <= sel_mask;
        pulse_r <= sel_pulse;
        ptr     <= (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
      end
      if (state == ISSUE) old_q <= q_in;
      // The bank updates on this same edge, so predict its JK next state
      // to have the post-op Q ready on the first RESP cycle.
      if ((state == ISSUE || state == RESTORE) && state_nx == RESP)
        rsp_q <= (j & ~q_in) | (~k & q_in);
    end
  end

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched with a JK bank model and a transaction-level reference.
module tb_jk_bank_sched;
  import jk_sched_pkg::*;

  localparam int NB = 4;
  localparam int NR = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [2*NR-1:0] req_op = '0;
  logic [NB*NR-1:0] req_mask = '0;
  logic [NR-1:0]   req_pulse = '0;
  logic [NR-1:0]   req_ready;
  logic [NB-1:0]   j, k, q_in, rsp_q;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;
  logic [NB-1:0] bank_m = '0;

  jk_bank_sched #(.N_BITS(NB), .N_REQ(NR), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_mask(req_mask), .req_pulse(req_pulse), .req_ready(req_ready),
    .j(j), .k(k), .q_in(q_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q)
  );

  always #5 clk = ~clk;

  // The JK register bank being scheduled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_in <= '0;
    else for (int b = 0; b < NB; b++)
      case ({j[b], k[b]})
        2'b01:   q_in[b] <= 1'b0;
        2'b10:   q_in[b] <= 1'b1;
        2'b11:   q_in[b] <= ~q_in[b];
        default: q_in[b] <= q_in[b];
      endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog sim time expired");
    $fatal(1);
  end

  task automatic set_req(input int r, input logic [1:0] op, input logic [NB-1:0] m, input bit p);
    req_op[2*r +: 2]     = op;
    req_mask[NB*r +: NB] = m;
    req_pulse[r]         = p;
    req_valid[r]         = 1'b1;
  endtask

  // Drive one transaction to completion from an IDLE negedge; ends on the next IDLE negedge.
  task automatic serve_one(input int stall, input bit keep, output int g);
    int guard, eg;
    logic [1:0] op;
    logic [NB-1:0] m, ej, ek, old, exq;
    logic [NR-1:0] exp_oh;
    bit p;
    g = -1; guard = 0; rsp_ready = 1'b0;
    #1;
    while (req_ready == '0 && guard < 12) begin
      @(negedge clk); #1; guard++;
    end
    n_vec++;
    if (req_ready == '0) begin
      n_err++; $display("FAIL grant_timeout req_ready=%b required=nonzero", req_ready);
      return;
    end
    eg = -1;
    for (int i = 0; i < NR; i++)
      if (eg < 0 && req_valid[(ptr_m + i) % NR]) eg = (ptr_m + i) % NR;
    exp_oh = '0; exp_oh[eg] = 1'b1;
    n_vec++;
    if (req_ready !== exp_oh) begin
      n_err++; $display("FAIL grant req_ready=%b required=%b", req_ready, exp_oh);
    end
    g = eg;
    op = req_op[2*g +: 2]; m = req_mask[NB*g +: NB]; p = req_pulse[g];
    ptr_m = (g + 1) % NR;
    old = bank_m;
    case (op)
      OP_CLR:  begin ej = '0; ek = m;  exq = old & ~m; end
      OP_SET:  begin ej = m;  ek = '0; exq = old | m;  end
      OP_TOG:  begin ej = m;  ek = m;  exq = old ^ m;  end
      default: begin ej = '0; ek = '0; exq = old;      end
    endcase
    if (p) exq = old;
    @(posedge clk); #1;
    if (!keep) req_valid[g] = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({j, k, rsp_valid, req_ready} !== {ej, ek, 1'b0, {NR{1'b0}}}) begin
      n_err++; $display("FAIL issue j=%b k=%b rv=%b rr=%b required j=%b k=%b rv=0 rr=0",
                        j, k, rsp_valid, req_ready, ej, ek);
    end
    if (p) begin
      @(negedge clk);
      n_vec++;
      if ({j, k, rsp_valid} !== {m & old, m & ~old, 1'b0}) begin
        n_err++; $display("FAIL restore j=%b k=%b rv=%b required j=%b k=%b rv=0",
                          j, k, rsp_valid, m & old, m & ~old);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_q, q_in, j, k} !== {1'b1, IW'(g), exq, exq, {NB{1'b0}}, {NB{1'b0}}}) begin
      n_err++; $display("FAIL resp rv=%b id=%0d q=%b bank=%b j=%b k=%b required rv=1 id=%0d q=%b j=k=0",
                        rsp_valid, rsp_id, rsp_q, q_in, j, k, g, exq);
    end
    bank_m = exq;
    rsp_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_q, req_ready, j, k} !== {1'b1, IW'(g), exq, {NR{1'b0}}, {NB{1'b0}}, {NB{1'b0}}}) begin
        n_err++; $display("FAIL stall rv=%b id=%0d q=%b rr=%b j=%b k=%b required rv=1 id=%0d q=%b rr=0 j=k=0",
                          rsp_valid, rsp_id, rsp_q, req_ready, j, k, g, exq);
      end
      if (s == stall - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL resp_done rsp_valid=%b required=0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({j, k, rsp_valid, req_ready, q_in, rsp_id, rsp_q} !== '0) begin
      n_err++; $display("FAIL reset j=%b k=%b rv=%b rr=%b bank=%b id=%0d q=%b required all zero",
                        j, k, rsp_valid, req_ready, q_in, rsp_id, rsp_q);
    end
    rst = 1'b0; ptr_m = 0; bank_m = '0;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if ({j, k, rsp_valid, req_ready, q_in} !== '0) begin
        n_err++; $display("FAIL idle j=%b k=%b rv=%b rr=%b bank=%b required all zero",
                          j, k, rsp_valid, req_ready, q_in);
      end
    end
  endtask

  task automatic test_single_set();
    int g;
    set_req(0, OP_SET, 4'b0101, 1'b0);
    serve_one(0, 1'b0, g);
  endtask

  task automatic test_pulse_tog();
    int g;
    set_req(1, OP_TOG, 4'b1111, 1'b1);
    serve_one(0, 1'b0, g);
  endtask

  task automatic test_backpressure();
    int g;
    set_req(0, OP_CLR, 4'b0001, 1'b0);
    set_req(1, OP_SET, 4'b1000, 1'b0);
    serve_one(3, 1'b0, g);
    serve_one(0, 1'b0, g);
  endtask

  task automatic test_round_robin();
    int g;
    rst = 1'b1;
    set_req(0, OP_SET, 4'b0011, 1'b0);
    set_req(1, OP_TOG, 4'b0110, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready req_ready=%b required=00", req_ready);
    end
    rst = 1'b0; ptr_m = 0; bank_m = '0;
    repeat (4) serve_one(0, 1'b1, g);
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    int guard, g;
    guard = 0;
    set_req(0, OP_CLR, 4'b1111, 1'b0);
    #1;
    while (req_ready == '0 && guard < 12) begin @(negedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = '0;
    n_vec++;
    if (k !== 4'b1111) begin
      n_err++; $display("FAIL arst_issue k=%b required=1111", k);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({j, k, rsp_valid, req_ready} !== '0) begin
      n_err++; $display("FAIL arst_outputs j=%b k=%b rv=%b rr=%b required all zero",
                        j, k, rsp_valid, req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({q_in, rsp_valid} !== '0) begin
      n_err++; $display("FAIL arst_bank bank=%b rv=%b required 0000 0", q_in, rsp_valid);
    end
    rst = 1'b0; ptr_m = 0; bank_m = '0;
    set_req(0, OP_SET, 4'b1000, 1'b0);
    set_req(1, OP_TOG, 4'b0011, 1'b0);
    serve_one(0, 1'b0, g);
    n_vec++;
    if (g !== 0) begin
      n_err++; $display("FAIL arst_first_grant g=%0d required=0", g);
    end
    serve_one(1, 1'b0, g);
  endtask

  task automatic test_random();
    int g, r;
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < NR; q++)
        if (!req_valid[q] && $urandom_range(0, 1) == 1)
          set_req(q, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (req_valid == '0) begin
        r = $urandom_range(0, NR - 1);
        set_req(r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      serve_one($urandom_range(0, 2), 1'b0, g);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_pulse_tog();
    test_backpressure();
    test_round_robin();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jk_bank_sched.md
Name: jk_bank_sched

Overview:
- Round-robin command scheduler that shares one bank of N_BITS JK flip-flops (clk, rst) among N_REQ requesters.
- Accepts one masked bit command (hold/clear/set/toggle, optional one-cycle pulse) per transaction.
- Drives the bank's J/K inputs for the required cycles, then returns the resulting Q to the requester.
- Sits between the JK register bank and the control agents that modify it.

Parameters:
- N_BITS, 8, width of the JK flip-flop bank.
- N_REQ, 2, number of requesters (>=2).
- ID_W, $clog2(N_REQ), width of requester index.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid; must be held until accepted.
- req_op  in  2*N_REQ  per-requester op: 00 HOLD, 01 CLR, 10 SET, 11 TOG.
- req_mask  in  N_BITS*N_REQ  per-requester bit mask.
- req_pulse  in  N_REQ  1 = restore masked bits to their pre-op value one cycle after applying the op.
- req_ready  out  N_REQ  one-hot grant/accept strobe.
- j  out  N_BITS  J inputs to the bank.
- k  out  N_BITS  K inputs to the bank.
- q_in  in  N_BITS  Q outputs of the bank.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the served requester.
- rsp_q  out  N_BITS  bank Q after the op completes.

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE, j=k=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0.
  - Round-robin pointer = 0.
- State machine: IDLE -> ISSUE -> [RESTORE] -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant the first valid index at or after the pointer, wrapping mod N_REQ.
  - req_ready[g]=1 for that cycle only; acceptance = valid & ready.
  - Latch op, mask, pulse and id. Pointer <= (g+1) mod N_REQ. Next state ISSUE.
  - req_ready is the only output with a combinational path from inputs; it is 0 in every state except IDLE.
- ISSUE (exactly 1 cycle):
  - j = mask & (SET|TOG ? 1 : 0); k = mask & (CLR|TOG ? 1 : 0); HOLD drives j=k=0.
  - Capture old_q <= q_in (pre-edge value).
  - Next state RESTORE if pulse, else RESP.
- RESTORE (1 cycle): j = mask & old_q; k = mask & ~old_q. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_id = latched id; rsp_q registered from q_in on entry; j=k=0.
  - Hold rsp_valid and fields stable until rsp_ready=1, then go to IDLE.
- j/k/rsp_* are decoded from registered state only. j=k=0 in IDLE and RESP.
- Latency from accept cycle t: ISSUE t+1; rsp_valid at t+2 (non-pulse) or t+3 (pulse). Back-to-back throughput: one transaction per 3 (4 with pulse) cycles when rsp_ready=1.
- Boundary conditions:
  - mask=0 or op=HOLD: no bits change, transaction still completes and reports q.
  - Requests arriving while busy wait; no queueing inside the block.
  - Dropping req_valid before ready is a protocol error; the block tolerates it (re-arbitrates only valid lines).
  - rst mid-operation: j/k and all outputs go to reset values immediately. The in-flight transaction is discarded with no response. The bank is reset by the same rst.
  - Single requester active: it is granted every IDLE visit regardless of pointer.

Decomposition:
- Package jk_sched_pkg:
  - op encoding constants (OP_HOLD/OP_CLR/OP_SET/OP_TOG).
  - FSM state enum (IDLE, ISSUE, RESTORE, RESP).
- Sub-module jk_rr_arbiter (N_REQ):
  - inputs: req vector, pointer.
  - outputs: one-hot grant, grant index, any.
- Top handles latching, FSM and J/K decode.

Test Plan (N_BITS=4, N_REQ=2, bank = N_BITS JK flip-flops on clk/rst):
- Assert rst=1 for 2 cycles -> j=k=0000, rsp_valid=0, req_ready=00, bank q=0000; release and idle with no requests -> outputs unchanged.
- Req0 SET mask 0101 pulse=0, rsp_ready=1 -> req_ready=01 at t; j=0101 k=0000 at t+1; rsp_valid at t+2 with rsp_id=0, rsp_q=0101.
- Req0 and req1 both held valid continuously from reset -> grant order 0,1,0,1; each response id matches its grant.
- From q=0101, req1 TOG mask 1111 pulse=1:
  - t+1: j=k=1111.
  - t+2: j=0101, k=1010.
  - t+3: rsp_q=0101, rsp_id=1.
- rsp_ready=0 for 3 cycles during RESP -> rsp_valid stays 1 with rsp_q/rsp_id stable, req_ready=00, j=k=0000; completes on the cycle rsp_ready=1.
- Assert rst asynchronously mid-ISSUE of a CLR mask 1111 -> j/k=0000 before the next edge, no rsp_valid; after release with both requesting, req0 is granted first.
